// File: rtl/engage_sequencer.sv
// Rover engagement sequencer: search, align, approach, fire, retreat.
// Decisions run on a tick spanning one detection window.
module engage_sequencer #(
  parameter int TICK_CYCLES    = 5000000,
  parameter int SEARCH_TICKS   = 20,
  parameter int ALIGN_TICKS    = 4,
  parameter int APPROACH_TICKS = 6,
  parameter int FIRE_TICKS     = 2,
  parameter int RETREAT_TICKS  = 3
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [1:0] forward_signal,
  input  logic [1:0] left_signal,
  input  logic [1:0] right_signal,
  output logic [2:0] drive_cmd,
  output logic       fire,
  output logic       busy,
  output logic       search_timeout,
  output logic [7:0] engage_count,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SEARCH   = 3'd1,
    ALIGN_L  = 3'd2,
    ALIGN_R  = 3'd3,
    APPROACH = 3'd4,
    FIRE     = 3'd5,
    RETREAT  = 3'd6
  } state_t;

  localparam logic [1:0] NONE   = 2'b00;
  localparam logic [1:0] FRIEND = 2'b01;
  localparam logic [1:0] ENEMY  = 2'b10;

  localparam logic [2:0] D_STOP = 3'd0;
  localparam logic [2:0] D_FWD  = 3'd1;
  localparam logic [2:0] D_TL   = 3'd2;
  localparam logic [2:0] D_TR   = 3'd3;
  localparam logic [2:0] D_REV  = 3'd4;

  localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PW-1:0] T_LAST = PW'(TICK_CYCLES - 1);

  localparam logic [7:0] S_LAST = 8'(SEARCH_TICKS - 1);
  localparam logic [7:0] A_LAST = 8'(ALIGN_TICKS - 1);
  localparam logic [7:0] P_LAST = 8'(APPROACH_TICKS - 1);
  localparam logic [7:0] F_LAST = 8'(FIRE_TICKS - 1);
  localparam logic [7:0] R_LAST = 8'(RETREAT_TICKS - 1);

  state_t        state, state_n;
  logic [PW-1:0] presc, presc_n;
  logic [7:0]    phase, phase_n;
  logic [7:0]    cnt_n;
  logic          dir_r, dir_n;
  logic          to_n;
  logic          tick;
  logic [1:0]    fwd, lft, rgt;

  function automatic logic [1:0] cls(input logic [1:0] s);
    return (s == 2'b11) ? NONE : s;
  endfunction

  function automatic logic [2:0] drv_of(input state_t s, input logic r);
    logic [2:0] d;
    d = D_STOP;
    unique case (s)
      SEARCH:   d = r ? D_TR : D_TL;
      ALIGN_L:  d = D_TL;
      ALIGN_R:  d = D_TR;
      APPROACH: d = D_FWD;
      RETREAT:  d = D_REV;
      default:  d = D_STOP;
    endcase
    return d;
  endfunction

  assign fwd       = cls(forward_signal);
  assign lft       = cls(left_signal);
  assign rgt       = cls(right_signal);
  assign tick      = (state != IDLE) && (presc == T_LAST);
  assign state_dbg = state;

  always_comb begin
    state_n = state;
    phase_n = phase;
    dir_n   = dir_r;
    to_n    = 1'b0;
    cnt_n   = engage_count;
    if (!enable) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE: state_n = SEARCH;
        SEARCH: if (tick) begin
          if (fwd == ENEMY)       state_n = APPROACH;
          else if (fwd == FRIEND) state_n = RETREAT;
          else if (lft == ENEMY)  state_n = ALIGN_L;
          else if (rgt == ENEMY)  state_n = ALIGN_R;
          else if (phase == S_LAST) begin
            dir_n   = ~dir_r;
            phase_n = 8'd0;
            to_n    = 1'b1;
          end else begin
            phase_n = phase + 8'd1;
          end
        end
        ALIGN_L, ALIGN_R: if (tick) begin
          if (fwd == ENEMY)         state_n = APPROACH;
          else if (fwd == FRIEND)   state_n = RETREAT;
          else if (phase == A_LAST) state_n = SEARCH;
          else                      phase_n = phase + 8'd1;
        end
        APPROACH: if (tick) begin
          if (fwd == FRIEND)        state_n = RETREAT;
          else if (fwd == NONE)     state_n = SEARCH;
          else if (phase == P_LAST) state_n = FIRE;
          else                      phase_n = phase + 8'd1;
        end
        FIRE: if (tick) begin
          if (phase == F_LAST) begin
            state_n = SEARCH;
            if (engage_count != 8'hff) cnt_n = engage_count + 8'd1;
          end else begin
            phase_n = phase + 8'd1;
          end
        end
        RETREAT: if (tick) begin
          if (phase == R_LAST) begin
            state_n = SEARCH;
            dir_n   = ~dir_r;
          end else begin
            phase_n = phase + 8'd1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
    if (state_n != state) phase_n = 8'd0;
  end

  // Prescaler stays cleared through IDLE and its exit edge
  always_comb begin
    presc_n = presc + PW'(1);
    if (state == IDLE || state_n == IDLE || tick) presc_n = '0;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state          <= IDLE;
      presc          <= '0;
      phase          <= 8'd0;
      dir_r          <= 1'b1;
      drive_cmd      <= D_STOP;
      fire           <= 1'b0;
      busy           <= 1'b0;
      search_timeout <= 1'b0;
      engage_count   <= 8'd0;
    end else begin
      state          <= state_n;
      presc          <= presc_n;
      phase          <= phase_n;
      dir_r          <= dir_n;
      drive_cmd      <= drv_of(state_n, dir_n);
      fire           <= (state_n == FIRE);
      busy           <= (state_n != IDLE);
      search_timeout <= to_n;
      engage_count   <= cnt_n;
    end
  end

endmodule

// File: tb/tb_engage_sequencer.sv
// Scoreboard bench for engage_sequencer with TICK_CYCLES=4.
// Output changes are events popped against a queue of expected events.
module tb_engage_sequencer;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       enable;
  logic [1:0] forward_signal;
  logic [1:0] left_signal;
  logic [1:0] right_signal;
  logic [2:0] drive_cmd;
  logic       fire;
  logic       busy;
  logic       search_timeout;
  logic [7:0] engage_count;
  logic [2:0] state_dbg;

  engage_sequencer #(.TICK_CYCLES(4)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .enable         (enable),
    .forward_signal (forward_signal),
    .left_signal    (left_signal),
    .right_signal   (right_signal),
    .drive_cmd      (drive_cmd),
    .fire           (fire),
    .busy           (busy),
    .search_timeout (search_timeout),
    .engage_count   (engage_count),
    .state_dbg      (state_dbg)
  );

  always #5 clock = ~clock;

  typedef struct {
    int         cyc;
    logic [2:0] st;
    logic [2:0] drv;
    logic       fi;
    logic       bz;
    logic       to;
    logic [7:0] cnt;
  } ev_t;

  ev_t q[$];
  int  cyc = 0;
  int  total = 0;
  int  passed = 0;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic ev_t mk(input int c, input logic [2:0] st,
                             input logic right, input logic to,
                             input logic [7:0] cnt);
    ev_t e;
    e.cyc = c;
    e.st  = st;
    case (st)
      3'd1:    e.drv = right ? 3'd3 : 3'd2;
      3'd2:    e.drv = 3'd2;
      3'd3:    e.drv = 3'd3;
      3'd4:    e.drv = 3'd1;
      3'd6:    e.drv = 3'd4;
      default: e.drv = 3'd0;
    endcase
    e.fi  = (st == 3'd5);
    e.bz  = (st != 3'd0);
    e.to  = to;
    e.cnt = cnt;
    return e;
  endfunction

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clock);
  endtask

  logic [15:0] cur;
  logic [15:0] prev = 16'hffff;
  ev_t         e;

  always @(negedge clock) begin
    if (cyc >= 1) begin
      cur = {state_dbg, drive_cmd, fire, busy, engage_count};
      if (cur !== prev || search_timeout !== 1'b0) begin
        total++;
        if (q.size() == 0) begin
          $display("FAIL unexpected_event cyc=%0d st=%0d drv=%0d fire=%b busy=%b to=%b cnt=%0d",
                   cyc, state_dbg, drive_cmd, fire, busy, search_timeout, engage_count);
        end else begin
          e = q.pop_front();
          if (e.cyc == cyc && e.st === state_dbg && e.drv === drive_cmd &&
              e.fi === fire && e.bz === busy && e.to === search_timeout &&
              e.cnt === engage_count) begin
            passed++;
          end else begin
            $display("FAIL event got cyc=%0d st=%0d drv=%0d fire=%b busy=%b to=%b cnt=%0d want cyc=%0d st=%0d drv=%0d fire=%b busy=%b to=%b cnt=%0d",
                     cyc, state_dbg, drive_cmd, fire, busy, search_timeout, engage_count,
                     e.cyc, e.st, e.drv, e.fi, e.bz, e.to, e.cnt);
          end
        end
      end
      prev = cur;
    end
  end

  initial begin
    reset_n        = 1'b0;
    enable         = 1'b0;
    forward_signal = 2'b00;
    left_signal    = 2'b00;
    right_signal   = 2'b00;
    q.push_back(mk(1, 3'd0, 1'b1, 1'b0, 8'd0));

    wait_cyc(2);
    reset_n = 1'b1;
    enable  = 1'b1;
    q.push_back(mk(3,   3'd1, 1'b1, 1'b0, 8'd0));
    q.push_back(mk(83,  3'd1, 1'b0, 1'b1, 8'd0));
    q.push_back(mk(163, 3'd1, 1'b1, 1'b1, 8'd0));

    wait_cyc(163);
    forward_signal = 2'b10;
    q.push_back(mk(167, 3'd4, 1'b1, 1'b0, 8'd0));
    q.push_back(mk(191, 3'd5, 1'b1, 1'b0, 8'd0));
    q.push_back(mk(199, 3'd1, 1'b1, 1'b0, 8'd1));
    wait_cyc(191);
    forward_signal = 2'b00;

    wait_cyc(199);
    forward_signal = 2'b10;
    q.push_back(mk(203, 3'd4, 1'b1, 1'b0, 8'd1));
    q.push_back(mk(219, 3'd6, 1'b1, 1'b0, 8'd1));
    q.push_back(mk(231, 3'd1, 1'b0, 1'b0, 8'd1));
    wait_cyc(215);
    forward_signal = 2'b01;
    wait_cyc(219);
    forward_signal = 2'b00;

    wait_cyc(231);
    left_signal  = 2'b10;
    right_signal = 2'b10;
    q.push_back(mk(235, 3'd2, 1'b0, 1'b0, 8'd1));
    q.push_back(mk(251, 3'd1, 1'b0, 1'b0, 8'd1));

    wait_cyc(251);
    left_signal    = 2'b00;
    right_signal   = 2'b00;
    forward_signal = 2'b10;
    q.push_back(mk(255, 3'd4, 1'b0, 1'b0, 8'd1));
    q.push_back(mk(279, 3'd5, 1'b0, 1'b0, 8'd1));
    wait_cyc(281);
    enable = 1'b0;
    q.push_back(mk(282, 3'd0, 1'b0, 1'b0, 8'd1));

    wait_cyc(284);
    enable = 1'b1;
    q.push_back(mk(285, 3'd1, 1'b0, 1'b0, 8'd1));
    for (int i = 0; i < 4; i++) begin
      q.push_back(mk(289 + 36*i, 3'd4, 1'b0, 1'b0, 8'(1 + i)));
      q.push_back(mk(313 + 36*i, 3'd5, 1'b0, 1'b0, 8'(1 + i)));
      q.push_back(mk(321 + 36*i, 3'd1, 1'b0, 1'b0, 8'(2 + i)));
    end

    wait_cyc(431);
    reset_n = 1'b0;
    q.push_back(mk(432, 3'd0, 1'b1, 1'b0, 8'd0));
    wait_cyc(433);
    reset_n = 1'b1;
    q.push_back(mk(434, 3'd1, 1'b1, 1'b0, 8'd0));
    q.push_back(mk(438, 3'd4, 1'b1, 1'b0, 8'd0));
    q.push_back(mk(442, 3'd1, 1'b1, 1'b0, 8'd0));
    wait_cyc(438);
    forward_signal = 2'b11;

    wait_cyc(442);
    forward_signal = 2'b10;
    for (int i = 0; i < 300; i++) begin
      q.push_back(mk(446 + 36*i, 3'd4, 1'b1, 1'b0, 8'((i > 255) ? 255 : i)));
      q.push_back(mk(470 + 36*i, 3'd5, 1'b1, 1'b0, 8'((i > 255) ? 255 : i)));
      q.push_back(mk(478 + 36*i, 3'd1, 1'b1, 1'b0,
                     8'((i + 1 > 255) ? 255 : i + 1)));
    end

    wait_cyc(11242);
    enable = 1'b0;
    q.push_back(mk(11243, 3'd0, 1'b1, 1'b0, 8'd255));
    wait_cyc(11250);

    while (q.size() > 0) begin
      e = q.pop_front();
      total++;
      $display("FAIL missing_event got none want cyc=%0d st=%0d cnt=%0d",
               e.cyc, e.st, e.cnt);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got cyc=%0d want finish by 11250", cyc);
    $fatal(1);
  end

endmodule
